regfile_wr_ctrl: RTL

//  Controller that owns the register file's single write port (sto/waddr/dataIn).

---
 rtl/regfile_wr_ctrl.sv | 117 +++++++++++
 1 files changed

// File: rtl/regfile_wr_ctrl.sv
// Write-port owner for the register file: zero-fills every register after reset, then
// round-robin arbitrates the ALU writeback (A) and load return (B) valid/ready requesters.
module regfile_wr_ctrl #(
   parameter int ADDR_W = 3,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              hold,
   input  logic              a_valid,
   input  logic [ADDR_W-1:0] a_addr,
   input  logic [DATA_W-1:0] a_data,
   output logic              a_ready,
   input  logic              b_valid,
   input  logic [ADDR_W-1:0] b_addr,
   input  logic [DATA_W-1:0] b_data,
   output logic              b_ready,
   output logic              rf_sto,
   output logic [ADDR_W-1:0] rf_waddr,
   output logic [DATA_W-1:0] rf_dataIn,
   output logic              init_done
);

   localparam int NREGS = 2**ADDR_W;

   typedef enum logic {ST_INIT, ST_RUN} state_t;
   typedef enum logic {RR_A, RR_B} rr_t;

   state_t            state_q, state_d;
   rr_t               rr_q, rr_d;
   logic [ADDR_W:0]   init_cnt_q, init_cnt_d;
   logic              rf_sto_q, rf_sto_d;
   logic [ADDR_W-1:0] rf_waddr_q, rf_waddr_d;
   logic [DATA_W-1:0] rf_data_q, rf_data_d;
   logic              init_done_q, init_done_d;

   logic a_accept;
   logic b_accept;

   assign a_accept = a_valid && a_ready;
   assign b_accept = b_valid && b_ready;

   always_comb begin
      state_d     = state_q;
      rr_d        = rr_q;
      init_cnt_d  = init_cnt_q;
      rf_sto_d    = 1'b0;
      rf_waddr_d  = rf_waddr_q;
      rf_data_d   = rf_data_q;
      init_done_d = init_done_q;
      a_ready     = 1'b0;
      b_ready     = 1'b0;

      case (state_q)
         ST_INIT: begin
            // The counter MSB sets exactly when all NREGS addresses have been written.
            if (!init_cnt_q[ADDR_W]) begin
               rf_sto_d   = 1'b1;
               rf_waddr_d = init_cnt_q[ADDR_W-1:0];
               rf_data_d  = '0;
               init_cnt_d = init_cnt_q + {{ADDR_W{1'b0}}, 1'b1};
            end else begin
               init_done_d = 1'b1;
               state_d     = ST_RUN;
            end
         end

         ST_RUN: begin
            a_ready = !hold && (!b_valid || (rr_q == RR_A));
            b_ready = !hold && (!a_valid || (rr_q == RR_B));

            // r0 is hard-wired zero: the handshake completes but the store is suppressed.
            if (a_accept) begin
               rf_sto_d   = (a_addr != '0);
               rf_waddr_d = a_addr;
               rf_data_d  = a_data;
               rr_d       = RR_B;
            end else if (b_accept) begin
               rf_sto_d   = (b_addr != '0);
               rf_waddr_d = b_addr;
               rf_data_d  = b_data;
               rr_d       = RR_A;
            end
         end

         default: begin
            state_d = ST_INIT;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= ST_INIT;
         rr_q        <= RR_A;
         init_cnt_q  <= '0;
         rf_sto_q    <= 1'b0;
         rf_waddr_q  <= '0;
         rf_data_q   <= '0;
         init_done_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         rr_q        <= rr_d;
         init_cnt_q  <= init_cnt_d;
         rf_sto_q    <= rf_sto_d;
         rf_waddr_q  <= rf_waddr_d;
         rf_data_q   <= rf_data_d;
         init_done_q <= init_done_d;
      end
   end

   assign rf_sto    = rf_sto_q;
   assign rf_waddr  = rf_waddr_q;
   assign rf_dataIn = rf_data_q;
   assign init_done = init_done_q;

endmodule
